// File: rtl/seven_seg_mux_scanner.sv
// Multiplexed common-anode seven-segment scanner: cycles DIGITS digits with a
// programmable dwell, optional ghosting guard, hex decode, DP and leading-zero blanking.
module seven_seg_mux_scanner #(
  parameter int DIGITS       = 4,
  parameter int DWELL        = 1,
  parameter int BLANK_CYCLES = 0,
  parameter int LZ_BLANK     = 1,
  localparam int SEL_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  div_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [4*DIGITS-1:0]   values,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            segment,
  output logic                  dp_n,
  output logic [SEL_W-1:0]      digit_sel,
  output logic                  frame_start
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  generate
    if (DIGITS < 1 || DIGITS > 8 || DWELL < 1 || BLANK_CYCLES < 0 ||
        BLANK_CYCLES > DWELL - 1 || (LZ_BLANK != 0 && LZ_BLANK != 1)) begin : g_param_check
      $error("seven_seg_mux_scanner: illegal parameter combination");
    end
  endgenerate

  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    case (nib)
      4'h0: seg_pattern = 7'h3F;
      4'h1: seg_pattern = 7'h06;
      4'h2: seg_pattern = 7'h5B;
      4'h3: seg_pattern = 7'h4F;
      4'h4: seg_pattern = 7'h66;
      4'h5: seg_pattern = 7'h6D;
      4'h6: seg_pattern = 7'h7D;
      4'h7: seg_pattern = 7'h07;
      4'h8: seg_pattern = 7'h7F;
      4'h9: seg_pattern = 7'h6F;
      4'hA: seg_pattern = 7'h77;
      4'hB: seg_pattern = 7'h7C;
      4'hC: seg_pattern = 7'h39;
      4'hD: seg_pattern = 7'h5E;
      4'hE: seg_pattern = 7'h79;
      default: seg_pattern = 7'h71;
    endcase
  endfunction

  logic [SEL_W-1:0] idx, idx_next;
  logic [CNT_W-1:0] dwell_cnt, cnt_next;

  // Scan position: dwell counter rolls into the digit index, both freeze while disabled.
  always_comb begin
    idx_next = idx;
    cnt_next = dwell_cnt;
    if (enable) begin
      if (dwell_cnt == CNT_LAST) begin
        cnt_next = '0;
        idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt_next = dwell_cnt + 1'b1;
      end
    end
  end

  logic in_guard;
  generate
    if (BLANK_CYCLES > 0) begin : g_guard
      assign in_guard = (dwell_cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

  logic [3:0]        nibble;
  logic              show_dp;
  logic              digit_on;
  logic              dark;
  logic              upper_run;
  logic [DIGITS-1:0] zero_blank;
  logic [DIGITS-1:0] onehot;

  // upper_run tracks "every nibble from here up to the top is zero", walking downward.
  always_comb begin
    nibble     = '0;
    show_dp    = 1'b0;
    digit_on   = 1'b0;
    onehot     = '0;
    zero_blank = '0;
    upper_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_run     = upper_run & (values[4*k +: 4] == 4'h0);
      zero_blank[k] = (LZ_BLANK == 1) && (k != 0) && upper_run && !dp[k];
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == SEL_W'(k)) begin
        nibble    = values[4*k +: 4];
        show_dp   = dp[k];
        digit_on  = digit_en[k] & ~zero_blank[k];
        onehot[k] = 1'b1;
      end
    end
    dark = !enable || in_guard || !digit_on;
  end

  always_ff @(posedge div_clock or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      dwell_cnt   <= '0;
      anode       <= '1;
      segment     <= 7'h7F;
      dp_n        <= 1'b1;
      digit_sel   <= '0;
      frame_start <= 1'b0;
    end else begin
      idx         <= idx_next;
      dwell_cnt   <= cnt_next;
      anode       <= dark ? '1 : ~onehot;
      segment     <= dark ? 7'h7F : ~seg_pattern(nibble);
      dp_n        <= dark ? 1'b1 : ~show_dp;
      digit_sel   <= idx;
      frame_start <= enable && (idx == '0) && (dwell_cnt == '0);
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_scanner.sv
// Bench for seven_seg_mux_scanner: three parameterisations driven together and
// compared every cycle against a frame-position model of the display.
module tb_seven_seg_mux_scanner;

  // ---------------- clock / reset ----------------
  logic div_clock = 1'b0;
  logic reset;
  logic enable;
  logic [31:0] values;
  logic [7:0]  dp;
  logic [7:0]  digit_en;

  always #5 div_clock = ~div_clock;

  logic [3:0] a_anode, b_anode;
  logic [7:0] c_anode;
  logic [6:0] a_segment, b_segment, c_segment;
  logic       a_dp_n, b_dp_n, c_dp_n;
  logic [1:0] a_sel, b_sel;
  logic [2:0] c_sel;
  logic       a_fs, b_fs, c_fs;

  seven_seg_mux_scanner #(.DIGITS(4), .DWELL(1), .BLANK_CYCLES(0), .LZ_BLANK(1)) u_a (
    .div_clock(div_clock), .reset(reset), .enable(enable),
    .digit_en(digit_en[3:0]), .values(values[15:0]), .dp(dp[3:0]),
    .anode(a_anode), .segment(a_segment), .dp_n(a_dp_n),
    .digit_sel(a_sel), .frame_start(a_fs));

  seven_seg_mux_scanner #(.DIGITS(4), .DWELL(4), .BLANK_CYCLES(1), .LZ_BLANK(1)) u_b (
    .div_clock(div_clock), .reset(reset), .enable(enable),
    .digit_en(digit_en[3:0]), .values(values[15:0]), .dp(dp[3:0]),
    .anode(b_anode), .segment(b_segment), .dp_n(b_dp_n),
    .digit_sel(b_sel), .frame_start(b_fs));

  seven_seg_mux_scanner #(.DIGITS(8), .DWELL(2), .BLANK_CYCLES(0), .LZ_BLANK(0)) u_c (
    .div_clock(div_clock), .reset(reset), .enable(enable),
    .digit_en(digit_en), .values(values), .dp(dp),
    .anode(c_anode), .segment(c_segment), .dp_n(c_dp_n),
    .digit_sel(c_sel), .frame_start(c_fs));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int n_en [3];
  logic [19:0] exp_q [$];

  logic [6:0] pat [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h (fs,sel,dpn,seg,anode)", tag, $time, got, want);
    end
  endtask

  // Packed view {frame_start, sel[2:0], dp_n, segment[6:0], anode[7:0]}.
  function automatic logic [19:0] obs(input int which);
    case (which)
      0:       return {a_fs, 1'b0, a_sel, a_dp_n, a_segment, 4'h0, a_anode};
      1:       return {b_fs, 1'b0, b_sel, b_dp_n, b_segment, 4'h0, b_anode};
      default: return {c_fs, c_sel, c_dp_n, c_segment, c_anode};
    endcase
  endfunction

  // Display expected after an edge, from the count of enabled edges n seen before it.
  function automatic logic [19:0] model(input int digits, input int dwell, input int blank,
                                        input int lz, input int n, input logic en,
                                        input logic [7:0] den, input logic [31:0] vals,
                                        input logic [7:0] dps);
    int pos, idx, cnt, mask, nib;
    logic [31:0] v;
    logic zb, dark, fs;
    logic [7:0] an;
    logic [6:0] seg;
    logic dpn;
    pos  = n % (digits * dwell);
    idx  = pos / dwell;
    cnt  = pos % dwell;
    mask = (1 << digits) - 1;
    v    = (digits == 8) ? vals : (vals & ((32'h1 << (4 * digits)) - 32'h1));
    nib  = int'((v >> (4 * idx)) & 32'hF);
    zb   = (lz == 1) && (idx != 0) && ((v >> (4 * idx)) == 32'h0) && !dps[idx];
    dark = !en || (cnt < blank) || !den[idx] || zb;
    fs   = en && (pos == 0);
    an   = dark ? 8'(mask) : 8'(mask & ~(1 << idx));
    seg  = dark ? 7'h7F : ~pat[nib];
    dpn  = dark ? 1'b1 : ~dps[idx];
    return {fs, 3'(idx), dpn, seg, an};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge div_clock);
    exp_q.push_back(model(4, 1, 0, 1, n_en[0], enable, digit_en, values, dp));
    exp_q.push_back(model(4, 4, 1, 1, n_en[1], enable, digit_en, values, dp));
    exp_q.push_back(model(8, 2, 0, 0, n_en[2], enable, digit_en, values, dp));
    if (enable) begin
      for (int i = 0; i < 3; i++) n_en[i]++;
    end
    @(negedge div_clock);
    check("scan_a", obs(0), exp_q.pop_front());
    check("scan_b", obs(1), exp_q.pop_front());
    check("scan_c", obs(2), exp_q.pop_front());
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a"}, obs(0), {1'b0, 3'd0, 1'b1, 7'h7F, 8'h0F});
    check({tag, "_b"}, obs(1), {1'b0, 3'd0, 1'b1, 7'h7F, 8'h0F});
    check({tag, "_c"}, obs(2), {1'b0, 3'd0, 1'b1, 7'h7F, 8'hFF});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    values   = '0;
    dp       = '0;
    digit_en = '0;
    for (int i = 0; i < 3; i++) n_en[i] = 0;
    repeat (2) @(negedge div_clock);
    check_reset("reset");
    reset = 1'b0;

    // Basic scan of 1234.
    enable   = 1'b1;
    digit_en = 8'hFF;
    values   = 32'h0000_1234;
    steps(10);
    check("a_first_frame_pos", 20'(n_en[0] % 4), 20'd2);

    // Leading-zero blanking, then a DP that defeats it on digit 3.
    values = 32'h0000_0042;
    steps(8);
    dp = 8'h08;
    steps(8);
    dp = 8'h00;

    // Freeze at idx=2, dwell 1 on the DWELL=4 instance.
    for (int i = 0; i < 32 && (n_en[1] % 16) != 9; i++) step();
    check("freeze_align", 20'(n_en[1] % 16), 20'd9);
    enable = 1'b0;
    steps(5);
    enable = 1'b1;
    steps(8);

    // Asynchronous reset mid-dwell at idx=3.
    for (int i = 0; i < 32 && (n_en[1] % 16) != 13; i++) step();
    @(posedge div_clock);
    #2 reset = 1'b1;
    #1 check_reset("async_reset");
    @(negedge div_clock);
    for (int i = 0; i < 3; i++) n_en[i] = 0;
    reset = 1'b0;
    steps(4);

    // Sparse digit enables on the eight-digit instance.
    digit_en = 8'b1011_0110;
    for (int i = 0; i < 40; i++) begin
      values = $urandom;
      dp     = 8'($urandom);
      step();
    end

    // Randomised traffic, with leading zeros made common.
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 7) != 0);
      digit_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      values   = $urandom >> (4 * $urandom_range(0, 8));
      dp       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step();
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
